// File: rtl/ahb_lite_burst_master.sv
`default_nettype none
// ============================================================================
// Module  : ahb_lite_burst_master
// Purpose : AHB-Lite bus master that takes one read/write command at a time
//           (1..2**LEN_W beats, selectable transfer size) and runs it as a
//           pipelined NONSEQ/SEQ burst. Inserts a NONSEQ restart at every
//           1 KB boundary, honours HREADY wait states and the two-cycle
//           ERROR response.
// Ports   : HCLK/HRESET        clock, asynchronous active-high reset
//           CMD_*              command valid/ready port
//           WR_DATA/WR_POP     show-ahead write data source
//           RD_DATA/RD_VALID   read data stream, one strobe per beat
//           DONE/ERROR         completion pulse, ERROR qualifies DONE
//           H*                 AHB-Lite master interface
// Revision: 1.0 - initial release
// ============================================================================
module ahb_lite_burst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [LEN_W-1:0]  CMD_LEN,
  input  logic [2:0]        CMD_SIZE,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              WR_POP,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic              DONE,
  output logic              ERROR,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] C_HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] C_HBURST_SINGLE = 3'b000;
  localparam logic [2:0] C_HBURST_INCR   = 3'b001;
  localparam logic [2:0] C_HBURST_INCR4  = 3'b011;
  localparam logic [2:0] C_HBURST_INCR8  = 3'b101;
  localparam logic [2:0] C_HBURST_INCR16 = 3'b111;

  // Holds a 1 KB offset plus the largest possible burst length in bytes.
  localparam int C_SPAN_W = LEN_W + 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t              state_q,      state_d;
  logic [ADDR_W-1:0]   haddr_q,      haddr_d;
  logic [1:0]          htrans_q,     htrans_d;
  logic                hwrite_q,     hwrite_d;
  logic [2:0]          hsize_q,      hsize_d;
  logic [2:0]          hburst_q,     hburst_d;
  logic [DATA_W-1:0]   hwdata_q,     hwdata_d;
  logic [LEN_W-1:0]    beats_left_q, beats_left_d;
  logic                dphase_q,     dphase_d;
  logic [DATA_W-1:0]   rd_data_q,    rd_data_d;
  logic                rd_valid_q,   rd_valid_d;
  logic                done_q,       done_d;
  logic                error_q,      error_d;

  logic [ADDR_W-1:0]   w_start_addr;
  logic [C_SPAN_W-1:0] w_beats;
  logic [C_SPAN_W-1:0] w_span_end;
  logic                w_crosses;
  logic [2:0]          w_burst;
  logic [ADDR_W-1:0]   w_next_addr;
  logic                w_next_crosses;
  logic                w_cmd_ready;
  logic                w_pop;

  // Command decode: align the start address and pick HBURST. A fixed-length
  // burst is only legal when the whole burst stays inside one 1 KB region.
  assign w_start_addr = CMD_ADDR & ({ADDR_W{1'b1}} << CMD_SIZE);
  assign w_beats      = C_SPAN_W'(CMD_LEN) + C_SPAN_W'(1);
  assign w_span_end   = C_SPAN_W'(w_start_addr[9:0]) + (w_beats << CMD_SIZE);
  assign w_crosses    = (w_span_end > C_SPAN_W'(1024));

  always_comb begin
    w_burst = C_HBURST_INCR;
    if (CMD_LEN == '0) begin
      w_burst = C_HBURST_SINGLE;
    end else if (!w_crosses) begin
      if (w_beats == C_SPAN_W'(4))       w_burst = C_HBURST_INCR4;
      else if (w_beats == C_SPAN_W'(8))  w_burst = C_HBURST_INCR8;
      else if (w_beats == C_SPAN_W'(16)) w_burst = C_HBURST_INCR16;
    end
  end

  // Addresses are size-aligned, so landing on a zero 10-bit offset means the
  // increment just stepped into a new 1 KB region: restart with NONSEQ.
  assign w_next_addr    = haddr_q + (ADDR_W'(1) << hsize_q);
  assign w_next_crosses = (w_next_addr[9:0] == 10'd0);

  // Ready is withheld during the DONE cycle so a new command starts only once
  // the completion pulse has been seen.
  assign w_cmd_ready = (state_q == ST_IDLE) && !done_q;

  always_comb begin
    state_d      = state_q;
    haddr_d      = haddr_q;
    htrans_d     = htrans_q;
    hwrite_d     = hwrite_q;
    hsize_d      = hsize_q;
    hburst_d     = hburst_q;
    hwdata_d     = hwdata_q;
    beats_left_d = beats_left_q;
    dphase_d     = dphase_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    done_d       = 1'b0;
    error_d      = 1'b0;
    w_pop        = 1'b0;

    // Any read data phase completing OKAY delivers one beat.
    if (dphase_q && !hwrite_q && HREADY && !HRESP) begin
      rd_valid_d = 1'b1;
      rd_data_d  = HRDATA;
    end

    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID && w_cmd_ready) begin
          haddr_d      = w_start_addr;
          htrans_d     = C_HTRANS_NONSEQ;
          hwrite_d     = CMD_WRITE;
          hsize_d      = CMD_SIZE;
          hburst_d     = w_burst;
          beats_left_d = CMD_LEN;
          state_d      = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (dphase_q && HRESP && !HREADY) begin
          // First error cycle: drop the pending beat and everything after it.
          htrans_d = C_HTRANS_IDLE;
          state_d  = ST_ERR;
        end else if (HREADY) begin
          dphase_d = 1'b1;
          if (hwrite_q) begin
            w_pop    = 1'b1;
            hwdata_d = WR_DATA;
          end
          if (beats_left_q == '0) begin
            htrans_d = C_HTRANS_IDLE;
            state_d  = ST_DRAIN;
          end else begin
            haddr_d      = w_next_addr;
            htrans_d     = w_next_crosses ? C_HTRANS_NONSEQ : C_HTRANS_SEQ;
            beats_left_d = beats_left_q - LEN_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (HRESP && !HREADY) begin
          state_d = ST_ERR;
        end else if (HREADY) begin
          dphase_d = 1'b0;
          done_d   = 1'b1;
          error_d  = HRESP;
          state_d  = ST_IDLE;
        end
      end

      ST_ERR: begin
        if (HREADY) begin
          dphase_d = 1'b0;
          done_d   = 1'b1;
          error_d  = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q      <= ST_IDLE;
      haddr_q      <= '0;
      htrans_q     <= C_HTRANS_IDLE;
      hwrite_q     <= 1'b0;
      hsize_q      <= '0;
      hburst_q     <= '0;
      hwdata_q     <= '0;
      beats_left_q <= '0;
      dphase_q     <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      haddr_q      <= haddr_d;
      htrans_q     <= htrans_d;
      hwrite_q     <= hwrite_d;
      hsize_q      <= hsize_d;
      hburst_q     <= hburst_d;
      hwdata_q     <= hwdata_d;
      beats_left_q <= beats_left_d;
      dphase_q     <= dphase_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign CMD_READY = w_cmd_ready;
  assign WR_POP    = w_pop;
  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;
  assign DONE      = done_q;
  assign ERROR     = error_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = hburst_q;
  assign HWDATA    = hwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_burst_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_ahb_lite_burst_master
// Purpose : Self-checking bench for ahb_lite_burst_master. The bench plays the
//           AHB slave and compares every cycle against a command-level model
//           (expected address list, burst type, data per beat, pulses).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ahb_lite_burst_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  localparam logic [1:0]  T_IDLE   = 2'b00;
  localparam logic [1:0]  T_NONSEQ = 2'b10;
  localparam logic [1:0]  T_SEQ    = 2'b11;
  localparam logic [31:0] HASH_K   = 32'h9E37_79B1;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              CMD_VALID, CMD_READY, CMD_WRITE;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [LEN_W-1:0]  CMD_LEN;
  logic [2:0]        CMD_SIZE;
  logic [DATA_W-1:0] WR_DATA;
  logic              WR_POP;
  logic [DATA_W-1:0] RD_DATA;
  logic              RD_VALID, DONE, ERROR;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE, HBURST;
  logic [DATA_W-1:0] HWDATA, HRDATA;
  logic              HREADY, HRESP;

  ahb_lite_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .CMD_SIZE(CMD_SIZE),
    .WR_DATA(WR_DATA), .WR_POP(WR_POP),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .DONE(DONE), .ERROR(ERROR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int n_vec = 0;
  int n_bad = 0;

  // Command-level model state.
  logic [31:0] salt;
  logic [31:0] m_addr[$];
  logic [1:0]  m_trans[$];
  logic [31:0] m_wdata[$];
  int          m_n;
  logic        m_write;
  logic [2:0]  m_size, m_burst;
  bit          cmd_active, cancelled, dp_valid, finished;
  int          k_acc, dp_idx, waits_left, err_beat, wait_beat, wait_n, err_phase;
  logic [31:0] dp_haddr;
  bit          exp_rdv, exp_done, exp_err;
  logic [31:0] exp_rdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave memory contents: a fixed function of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return salt ^ (a * HASH_K);
  endfunction

  task automatic check_rst(input string pfx);
    check({pfx, "_htrans"},    64'(HTRANS),    64'(T_IDLE));
    check({pfx, "_haddr"},     64'(HADDR),     64'(0));
    check({pfx, "_hburst"},    64'(HBURST),    64'(0));
    check({pfx, "_hwdata"},    64'(HWDATA),    64'(0));
    check({pfx, "_wr_pop"},    64'(WR_POP),    64'(0));
    check({pfx, "_rd_valid"},  64'(RD_VALID),  64'(0));
    check({pfx, "_done"},      64'(DONE),      64'(0));
    check({pfx, "_error"},     64'(ERROR),     64'(0));
    check({pfx, "_cmd_ready"}, 64'(CMD_READY), 64'(1));
  endtask

  // One bus cycle. Entered 1 time unit after a rising edge.
  task automatic step();
    bit          pres, nrdv, ndone, nerr;
    logic [31:0] nrdata;
    pres = cmd_active && !cancelled && (k_acc < m_n);
    HRESP  = 1'b0;
    HREADY = 1'b1;
    HRDATA = $urandom;
    if (dp_valid) begin
      if (waits_left > 0) begin
        HREADY = 1'b0;
        waits_left--;
      end else if (dp_idx == err_beat) begin
        if (err_phase == 0) begin HREADY = 1'b0; HRESP = 1'b1; err_phase = 1; end
        else begin HREADY = 1'b1; HRESP = 1'b1; err_phase = 2; end
      end else if (!m_write) begin
        HRDATA = mem_word(dp_haddr);
      end
    end
    WR_DATA   = (pres && m_write) ? m_wdata[k_acc] : $urandom;
    // Junk commands while busy must be ignored.
    CMD_VALID = cmd_active ? 1'($urandom_range(0, 1)) : 1'b0;
    CMD_WRITE = 1'($urandom);
    CMD_ADDR  = $urandom;
    CMD_LEN   = LEN_W'($urandom);
    CMD_SIZE  = 3'($urandom_range(0, 2));

    @(negedge HCLK);
    check("htrans", 64'(HTRANS), 64'(pres ? m_trans[k_acc] : T_IDLE));
    if (pres) begin
      check("haddr",  64'(HADDR),  64'(m_addr[k_acc]));
      check("hburst", 64'(HBURST), 64'(m_burst));
      check("hsize",  64'(HSIZE),  64'(m_size));
      check("hwrite", 64'(HWRITE), 64'(m_write));
    end
    check("wr_pop", 64'(WR_POP), 64'(pres && m_write && HREADY));
    if (dp_valid && m_write) check("hwdata", 64'(HWDATA), 64'(m_wdata[dp_idx]));
    check("rd_valid", 64'(RD_VALID), 64'(exp_rdv));
    if (exp_rdv) check("rd_data", 64'(RD_DATA), 64'(exp_rdata));
    check("done",  64'(DONE),  64'(exp_done));
    check("error", 64'(ERROR), 64'(exp_err));
    if (cmd_active)     check("cmd_ready_busy", 64'(CMD_READY), 64'(0));
    else if (!exp_done) check("cmd_ready_idle", 64'(CMD_READY), 64'(1));
    if (exp_done) finished = 1'b1;

    // Predict the effect of the coming edge.
    nrdv = 1'b0; ndone = 1'b0; nerr = 1'b0; nrdata = '0;
    if (dp_valid && HREADY) begin
      if (HRESP) begin
        ndone = 1'b1;
        nerr  = 1'b1;
      end else begin
        if (!m_write) begin nrdv = 1'b1; nrdata = mem_word(m_addr[dp_idx]); end
        if (dp_idx == m_n - 1) ndone = 1'b1;
      end
      dp_valid = 1'b0;
    end
    if (HRESP && !HREADY) cancelled = 1'b1;
    if (pres && HREADY) begin
      dp_valid   = 1'b1;
      dp_idx     = k_acc;
      dp_haddr   = HADDR;
      waits_left = (k_acc == wait_beat) ? wait_n : 0;
      k_acc++;
    end
    exp_rdv = nrdv; exp_rdata = nrdata; exp_done = ndone; exp_err = nerr;
    if (ndone) cmd_active = 1'b0;
    @(posedge HCLK); #1;
  endtask

  task automatic mid_reset();
    #2 HRESET = 1'b1;
    #1 check_rst("midrst");
    cmd_active = 0; dp_valid = 0; cancelled = 0; k_acc = 0; m_n = 0;
    exp_rdv = 0; exp_done = 0; exp_err = 0;
    CMD_VALID = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    @(posedge HCLK); #3 HRESET = 1'b0;
    @(posedge HCLK); #1;
    repeat (3) step();
  endtask

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input int len, input int size,
                         input int eb, input int wb, input int wn, input int abort_at, input bit seq_data);
    logic [31:0] start, a, bytes;
    int cyc;
    m_addr.delete(); m_trans.delete(); m_wdata.delete();
    m_n = len + 1; m_write = wr; m_size = 3'(size);
    bytes = 32'(1) << size;
    start = addr & ~(bytes - 32'(1));
    for (int j = 0; j < m_n; j++) begin
      a = start + 32'(j) * bytes;
      m_addr.push_back(a);
      m_trans.push_back((j == 0 || a[9:0] == 10'd0) ? T_NONSEQ : T_SEQ);
      m_wdata.push_back(seq_data ? 32'(j + 1) : $urandom);
    end
    if (m_n == 1) m_burst = 3'b000;
    else if ((start >> 10) != ((start + 32'(m_n) * bytes - 32'(1)) >> 10)) m_burst = 3'b001;
    else if (m_n == 4)  m_burst = 3'b011;
    else if (m_n == 8)  m_burst = 3'b101;
    else if (m_n == 16) m_burst = 3'b111;
    else m_burst = 3'b001;

    err_beat = eb; wait_beat = wb; wait_n = wn; err_phase = 0;
    cancelled = 0; dp_valid = 0; k_acc = 0; waits_left = 0;
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr;
    CMD_LEN = LEN_W'(len); CMD_SIZE = 3'(size);
    HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    check("cmd_ready_accept", 64'(CMD_READY), 64'(1));
    check("htrans_pre", 64'(HTRANS), 64'(T_IDLE));
    @(posedge HCLK); #1;
    CMD_VALID = 1'b0;
    cmd_active = 1'b1; finished = 1'b0;
    exp_rdv = 0; exp_done = 0; exp_err = 0;
    cyc = 0;
    while (!finished) begin
      if (abort_at > 0 && cyc == abort_at) begin
        mid_reset();
        return;
      end
      if (cyc >= 300) begin
        n_vec++; n_bad++;
        $display("FAIL timeout: command still open after %0d cycles", cyc);
        cmd_active = 0; dp_valid = 0;
        break;
      end
      step();
      cyc++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len, eb;
    HRESET = 1'b1; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0;
    CMD_LEN = '0; CMD_SIZE = '0; WR_DATA = '0; HRDATA = '0;
    HREADY = 1'b1; HRESP = 1'b0;
    salt = 32'hCAFE_F00D ^ (32'h100 * HASH_K);
    cmd_active = 0; dp_valid = 0; cancelled = 0; finished = 0;
    k_acc = 0; m_n = 0; exp_rdv = 0; exp_done = 0; exp_err = 0;
    #3 check_rst("rst");
    #9 HRESET = 1'b0;
    @(posedge HCLK); #1;
    step();

    // Single read at 0x100 returning 0xCAFEF00D.
    run_cmd(1'b0, 32'h100, 0, 2, -1, -1, 0, 0, 1'b0);
    // INCR4 write, data 1..4.
    run_cmd(1'b1, 32'h40, 3, 2, -1, -1, 0, 0, 1'b1);
    // INCR8 read, two wait states on beat 3.
    run_cmd(1'b0, 32'h200, 7, 2, -1, 2, 2, 0, 1'b0);
    // 1 KB crossing, read and write.
    run_cmd(1'b0, 32'h3F8, 3, 2, -1, -1, 0, 0, 1'b0);
    run_cmd(1'b1, 32'h3F8, 3, 2, -1, -1, 0, 0, 1'b0);
    // INCR4 read with error on beat 2, then a normal command.
    run_cmd(1'b0, 32'h80, 3, 2, 1, -1, 0, 0, 1'b0);
    run_cmd(1'b1, 32'h502, 1, 1, -1, -1, 0, 0, 1'b0);
    // Error on the last beat of a write.
    run_cmd(1'b1, 32'h700, 3, 2, 3, -1, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(0, 15);
      eb  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : -1;
      run_cmd(1'($urandom), $urandom & 32'h0000_0FFF, len, $urandom_range(0, 2),
              eb, $urandom_range(0, len), $urandom_range(0, 3), 0, 1'b0);
    end

    // Asynchronous reset in the middle of a 16-beat write, then recovery.
    run_cmd(1'b1, 32'h600, 15, 2, -1, 3, 1, 6, 1'b0);
    run_cmd(1'b0, 32'h640, 7, 2, -1, -1, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
